// File: rtl/fifo_read_adapter_pkg.sv
// Shared constants and helpers for the FIFO read adapter.
//   DEF_WIDTH / DEF_LATENCY / DEF_BUF_DEPTH : default parameter values
//   clog2(n) : ceil(log2(n)), usable in constant expressions
package fifo_read_adapter_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_LATENCY   = 2;
  localparam int DEF_BUF_DEPTH = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_skid_buffer.sv
// Local storage for words returned by the FIFO: a buf_depth x width register
// array, wrapping write/read pointers and an occupancy count. The head entry
// is presented combinationally (first-word-fall-through); a word written this
// cycle becomes visible on the next cycle, never bypassed.
//   dout_clock, reset_n : clock, async active-low reset
//   i_wr, i_wdata       : write strobe and word
//   i_pop               : advance read pointer (caller only pops when o_valid)
//   o_rdata, o_valid    : head word and non-empty flag
//   o_occ               : number of buffered words, 0..buf_depth
module fifo_skid_buffer
  import fifo_read_adapter_pkg::*;
#(
  parameter int width     = DEF_WIDTH,
  parameter int buf_depth = DEF_BUF_DEPTH
) (
  input  logic                      dout_clock,
  input  logic                      reset_n,
  input  logic                      i_wr,
  input  logic [width-1:0]          i_wdata,
  input  logic                      i_pop,
  output logic [width-1:0]          o_rdata,
  output logic                      o_valid,
  output logic [clog2(buf_depth):0] o_occ
);

  localparam int PW = clog2(buf_depth);
  localparam int OW = PW + 1;

  logic [buf_depth-1:0][width-1:0] r_mem;
  logic [PW-1:0]                   r_wptr;
  logic [PW-1:0]                   r_rptr;
  logic [OW-1:0]                   r_occ;

  // Pointers wrap naturally since buf_depth is a power of two.
  always_ff @(posedge dout_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mem  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (i_wr) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (i_pop) r_rptr <= r_rptr + PW'(1);
      case ({i_wr, i_pop})
        2'b10:   r_occ <= r_occ + OW'(1);
        2'b01:   r_occ <= r_occ - OW'(1);
        default: ;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_valid = (r_occ != '0);
  assign o_occ   = r_occ;

  // The credit check upstream makes a write into a full buffer impossible.
  a_no_overflow: assert property (@(posedge dout_clock) disable iff (!reset_n)
    !(i_wr && (r_occ == OW'(buf_depth))));

endmodule

// File: rtl/fifo_read_adapter.sv
// Turns a fixed-latency, no-backpressure FIFO read port into a valid/ready
// stream. A read is issued only when the skid buffer is guaranteed to have a
// free slot for it when it returns: buffered + in-flight + this read must fit,
// counting the slot freed by a pop in the same cycle.
//   dout_clock, reset_n          : clock, async active-low reset
//   fifo_ready / fifo_read       : FIFO non-empty / read strobe (combinational)
//   fifo_data, fifo_data_valid   : returned word, latency cycles after a read
//   out_data, out_valid, out_ready : downstream stream
module fifo_read_adapter
  import fifo_read_adapter_pkg::*;
#(
  parameter int width     = DEF_WIDTH,
  parameter int latency   = DEF_LATENCY,
  parameter int buf_depth = DEF_BUF_DEPTH
) (
  input  logic             dout_clock,
  input  logic             reset_n,
  input  logic             fifo_ready,
  output logic             fifo_read,
  input  logic [width-1:0] fifo_data,
  input  logic             fifo_data_valid,
  output logic [width-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int IW = clog2(latency + 1) + 1;
  localparam int OW = clog2(buf_depth) + 1;
  localparam int CW = OW + 1;  // headroom for occ + inflight + 1

  logic [IW-1:0] r_inflight;
  logic [OW-1:0] w_occ;
  logic          w_pop;
  logic [CW-1:0] w_need;
  logic [CW-1:0] w_room;

  assign w_pop  = out_valid & out_ready;
  assign w_need = {1'b0, w_occ} + CW'(r_inflight) + CW'(1);
  assign w_room = CW'(buf_depth) + CW'(w_pop);

  // reset_n gates the strobe so nothing is issued while held in reset.
  assign fifo_read = reset_n & fifo_ready & (w_need <= w_room);

  always_ff @(posedge dout_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_inflight <= '0;
    end else begin
      case ({fifo_read, fifo_data_valid})
        2'b10:   r_inflight <= r_inflight + IW'(1);
        2'b01:   r_inflight <= r_inflight - IW'(1);
        default: ;
      endcase
    end
  end

  fifo_skid_buffer #(
    .width     (width),
    .buf_depth (buf_depth)
  ) u_buf (
    .dout_clock (dout_clock),
    .reset_n    (reset_n),
    .i_wr       (fifo_data_valid),
    .i_wdata    (fifo_data),
    .i_pop      (w_pop),
    .o_rdata    (out_data),
    .o_valid    (out_valid),
    .o_occ      (w_occ)
  );

  // A returned word with nothing outstanding means the FIFO broke protocol.
  a_no_orphan_return: assert property (@(posedge dout_clock) disable iff (!reset_n)
    !(fifo_data_valid && (r_inflight == '0)));

endmodule
